reg_load_arbiter: RTL

Round-robin arbiter and load sequencer for one shared N-bit load-enabled register. Up to R requesters each present a data word and a request. The block picks one winner per cycle and drives the register's data and load inputs. An optional lock lets the current owner keep the register for bounded back-to-back loads. It sits between requester logic and the shared register instance and is the only agent allowed to drive that register's load.

---
 rtl/reg_load_arbiter_pkg.sv | 15 +
 rtl/reg_load_arbiter_rr_pick.sv | 32 +++
 rtl/reg_load_arbiter.sv | 75 +++++++
 3 files changed

// File: rtl/reg_load_arbiter_pkg.sv
// Shared types and width helpers for the shared-register load arbiter.
package reg_load_arbiter_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

  // Index width for requester pointers; at least one bit even for tiny R.
  function automatic int ptr_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic int hold_w(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_pick
  import reg_load_arbiter_pkg::*;
#(
  parameter int R  = 4,
  parameter int PW = ptr_w(R)
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [2*R-1:0] sh;
  logic [R-1:0]   rot;
  int             off;
  int             sum;

  always_comb begin
    sh    = {req, req} >> (int'(ptr) + 1);
    rot   = sh[R-1:0];
    found = |rot;
    off   = 0;
    // Scan downward so the lowest set bit (closest to ptr+1) wins.
    for (int j = R - 1; j >= 0; j--)
      if (rot[j]) off = j;
    sum = int'(ptr) + 1 + off;
    if (sum >= R) sum = sum - R;
    idx = PW'(sum);
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter with bounded lock; drives data/load of one shared register.
module reg_load_arbiter
  import reg_load_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int R        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [R-1:0]         req,
  input  logic [R-1:0]         lock,
  input  logic [R*N-1:0]       din,
  output logic [R-1:0]         grant,
  output logic                 load,
  output logic [N-1:0]         dout,
  output logic [ptr_w(R)-1:0]  owner
);

  localparam int PW = ptr_w(R);
  localparam int HW = hold_w(MAX_HOLD);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, win;
  logic [HW-1:0] hold_q, hold_d;
  logic [R-1:0]  others, grant_d;
  logic          keep, found;
  logic [PW-1:0] pick;

  rr_pick #(.R(R), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    others        = req;
    others[owner] = 1'b0;
    keep = (state_q == OWN) && req[owner] && lock[owner] &&
           ((others == '0) || (int'(hold_q) < MAX_HOLD - 1));
    win     = keep ? owner : pick;
    state_d = (keep || found) ? OWN : IDLE;
    grant_d = '0;
    hold_d  = '0;
    if (state_d == OWN) begin
      grant_d[win] = 1'b1;
      // A lone locked owner at the limit is re-granted with a fresh count.
      if (keep && int'(hold_q) < MAX_HOLD - 1) hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(R - 1);
      owner   <= '0;
      hold_q  <= '0;
      grant   <= '0;
      load    <= 1'b0;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      grant   <= grant_d;
      load    <= (state_d == OWN);
      if (state_d == OWN) begin
        ptr_q <= win;
        owner <= win;
        dout  <= din[int'(win)*N +: N];
      end
    end
  end

endmodule
